// File: rtl/qspi_arb.sv
// qspi_arb
// Shares the single QSPI line-transfer engine between three requesters:
// the instruction-cache fill (i), the data-cache writeback/fill (d) and an
// auxiliary line mover (x). The winner's tag, direction and memory select
// are latched. The engine is then held until it reports line completion.
// The winner gets a one-cycle done pulse afterwards.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rom_enable              QSPI ROM mode enable from execute
//   i_req / i_tag / i_done  icache line fill request, tag, completion pulse
//   d_req / d_write / d_tag / d_done
//                           dcache line transfer request, direction
//                           (1 = writeback), tag, completion pulse
//   x_req / x_write / x_mem / x_tag / x_done
//                           aux line mover request, direction, memory/ROM
//                           select, tag, completion pulse
//   q_req, q_i_d, q_write, q_mem, q_paddr
//                           request and transfer fields presented to qspi
//   q_done                  qspi reports the last nibble of the line
//   busy                    arbiter is not idle
//   owner                   current owner: 0 none, 1 i, 2 d, 3 x
module qspi_arb #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int X_WAIT_MAX  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              rom_enable,
  input  logic                              i_req,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] i_tag,
  output logic                              i_done,
  input  logic                              d_req,
  input  logic                              d_write,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] d_tag,
  output logic                              d_done,
  input  logic                              x_req,
  input  logic                              x_write,
  input  logic                              x_mem,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] x_tag,
  output logic                              x_done,
  output logic                              q_req,
  output logic                              q_i_d,
  output logic                              q_write,
  output logic                              q_mem,
  output logic [PA-$clog2(LINE_LENGTH)-1:0] q_paddr,
  input  logic                              q_done,
  output logic                              busy,
  output logic [1:0]                        owner
);

  localparam int XW = $clog2(X_WAIT_MAX + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_X    = 2'd3;

  localparam logic [XW-1:0] X_WAIT_LIMIT = XW'(X_WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] x_wait;
  logic          pair;

  logic [1:0]    grant;
  logic          grant_cont;

  // Winner selection for the current IDLE cycle.
  // A fill that directly follows a dcache writeback keeps the engine with d,
  // so an evict-then-refill pair completes back to back. After that pair
  // rule, an x that has been passed over X_WAIT_MAX times is forced to win.
  // Otherwise d beats i, and i beats x.
  always_comb begin
    grant      = OWN_NONE;
    grant_cont = 1'b0;
    if (pair && d_req && !d_write) begin
      grant      = OWN_D;
      grant_cont = 1'b1;
    end else if (x_req && (x_wait == X_WAIT_LIMIT)) begin
      grant = OWN_X;
    end else if (d_req) begin
      grant = OWN_D;
    end else if (i_req) begin
      grant = OWN_I;
    end else if (x_req) begin
      grant = OWN_X;
    end
  end

  // busy follows the state register directly, so it is glitch-free and
  // lines up with the registered q_req.
  assign busy = (state != IDLE);

  // Arbiter FSM. All qspi-facing fields are registered at grant time. They
  // then stay frozen until the next grant, so qspi sees stable values for
  // the whole line. Request inputs are not looked at during XFER, because
  // qspi cannot abort a line once it has started.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_mem   <= 1'b0;
      q_paddr <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      x_done  <= 1'b0;
      x_wait  <= '0;
      pair    <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      x_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != OWN_NONE) begin
            state <= XFER;
            owner <= grant;
            q_req <= 1'b1;
            case (grant)
              OWN_I: begin
                q_paddr <= i_tag;
                q_write <= 1'b0;
                q_mem   <= rom_enable;
                q_i_d   <= 1'b1;
              end
              OWN_D: begin
                q_paddr <= d_tag;
                q_write <= d_write;
                q_mem   <= rom_enable && !d_write;
                q_i_d   <= 1'b0;
              end
              default: begin
                q_paddr <= x_tag;
                q_write <= x_write;
                q_mem   <= x_mem;
                q_i_d   <= 1'b0;
              end
            endcase
            // Each time x is passed over while it is asking, it gets one
            // step closer to a forced win.
            if (grant == OWN_X) begin
              x_wait <= '0;
            end else if (x_req && (x_wait != X_WAIT_LIMIT)) begin
              x_wait <= x_wait + 1'b1;
            end
            if (!grant_cont) begin
              pair <= 1'b0;
            end
          end
        end
        XFER: begin
          if (q_done) begin
            state <= TURN;
            q_req <= 1'b0;
            case (owner)
              OWN_I:   i_done <= 1'b1;
              OWN_D:   d_done <= 1'b1;
              OWN_X:   x_done <= 1'b1;
              default: ;
            endcase
          end
        end
        TURN: begin
          // This is the idle gap qspi uses to release chip select. A d
          // writeback arms the pair rule for the following grant.
          pair  <= (owner == OWN_D) && q_write;
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb
// Directed bench for qspi_arb. The bench uses the default parameters:
// PA=22, LINE_LENGTH=4 (20-bit tags) and X_WAIT_MAX=4. Inputs change 1 time
// unit after a rising edge. Outputs are sampled at that same point.
module tb_qspi_arb;

  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          rom_enable;
  logic          i_req;
  logic [TW-1:0] i_tag;
  logic          i_done;
  logic          d_req;
  logic          d_write;
  logic [TW-1:0] d_tag;
  logic          d_done;
  logic          x_req;
  logic          x_write;
  logic          x_mem;
  logic [TW-1:0] x_tag;
  logic          x_done;
  logic          q_req;
  logic          q_i_d;
  logic          q_write;
  logic          q_mem;
  logic [TW-1:0] q_paddr;
  logic          q_done;
  logic          busy;
  logic [1:0]    owner;

  int vectors     = 0;
  int miscompares = 0;

  qspi_arb dut (
    .clk(clk), .reset(reset), .rom_enable(rom_enable),
    .i_req(i_req), .i_tag(i_tag), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_done(d_done),
    .x_req(x_req), .x_write(x_write), .x_mem(x_mem), .x_tag(x_tag),
    .x_done(x_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem),
    .q_paddr(q_paddr), .q_done(q_done), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic dr,
                               input logic dw, input logic xr);
    i_req   = ir;
    d_req   = dr;
    d_write = dw;
    x_req   = xr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Checks the fields expected right after a grant edge.
  task automatic checkGrant(input string tag, input logic [1:0] own,
                            input logic [TW-1:0] paddr, input logic wr,
                            input logic mem, input logic iid);
    checkOutput({tag, ".owner"},   32'(owner),   32'(own));
    checkOutput({tag, ".q_req"},   32'(q_req),   32'd1);
    checkOutput({tag, ".busy"},    32'(busy),    32'd1);
    checkOutput({tag, ".q_paddr"}, 32'(q_paddr), 32'(paddr));
    checkOutput({tag, ".q_write"}, 32'(q_write), 32'(wr));
    checkOutput({tag, ".q_mem"},   32'(q_mem),   32'(mem));
    checkOutput({tag, ".q_i_d"},   32'(q_i_d),   32'(iid));
  endtask

  // Pulses q_done and checks the TURN cycle: one done pulse for the owner.
  task automatic finishXfer(input string tag, input logic [2:0] done_exp);
    q_done = 1'b1;
    tick();
    q_done = 1'b0;
    checkOutput({tag, ".turn_q_req"}, 32'(q_req), 32'd0);
    checkOutput({tag, ".turn_busy"},  32'(busy),  32'd1);
    checkOutput({tag, ".turn_done"},  32'({i_done, d_done, x_done}),
                32'(done_exp));
  endtask

  // Steps from TURN into IDLE. The done pulse must be gone by then.
  task automatic toIdle(input string tag);
    tick();
    checkOutput({tag, ".idle_busy"},  32'(busy),  32'd0);
    checkOutput({tag, ".idle_owner"}, 32'(owner), 32'd0);
    checkOutput({tag, ".idle_done"},  32'({i_done, d_done, x_done}), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    rom_enable = 1'b0;
    q_done     = 1'b0;
    i_tag      = '0;
    d_tag      = '0;
    x_tag      = '0;
    x_write    = 1'b0;
    x_mem      = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    checkOutput("rst.q_req",   32'(q_req),   32'd0);
    checkOutput("rst.owner",   32'(owner),   32'd0);
    checkOutput("rst.busy",    32'(busy),    32'd0);
    checkOutput("rst.q_paddr", 32'(q_paddr), 32'd0);
    checkOutput("rst.q_mode",  32'({q_i_d, q_write, q_mem}), 32'd0);
    checkOutput("rst.done",    32'({i_done, d_done, x_done}), 32'd0);

    // Stray q_done while idle with no requests has no effect.
    q_done = 1'b1;
    tick();
    q_done = 1'b0;
    checkOutput("stray.busy", 32'(busy), 32'd0);
    checkOutput("stray.done", 32'({i_done, d_done, x_done}), 32'd0);

    // All three requests arrive together: the order is d, then i, then x.
    rom_enable = 1'b1;
    i_tag = 20'h00111;
    d_tag = 20'h00222;
    x_tag = 20'h00333;
    x_write = 1'b1;
    x_mem   = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkGrant("tri_d", 2'd2, 20'h00222, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("tri_d.hold_q_req",   32'(q_req),   32'd1);
    checkOutput("tri_d.hold_q_paddr", 32'(q_paddr), 32'h00222);
    finishXfer("tri_d", 3'b010);
    d_req = 1'b0;
    toIdle("tri_d");
    tick();
    checkGrant("tri_i", 2'd1, 20'h00111, 1'b0, 1'b1, 1'b1);
    finishXfer("tri_i", 3'b100);
    i_req = 1'b0;
    toIdle("tri_i");
    tick();
    checkGrant("tri_x", 2'd3, 20'h00333, 1'b1, 1'b1, 1'b0);
    finishXfer("tri_x", 3'b001);
    x_req = 1'b0;
    toIdle("tri_x");

    // i drops its request in the second XFER cycle. The line still completes.
    i_tag = 20'h000AA;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkGrant("drop_i", 2'd1, 20'h000AA, 1'b0, 1'b1, 1'b1);
    tick();
    i_req = 1'b0;
    tick();
    checkOutput("drop_i.q_req_held", 32'(q_req), 32'd1);
    finishXfer("drop_i", 3'b100);
    toIdle("drop_i");
    tick();
    checkOutput("drop_i.no_grant_owner", 32'(owner), 32'd0);
    checkOutput("drop_i.no_grant_q_req", 32'(q_req), 32'd0);

    // A writeback and then a fill from d runs ahead of a waiting i.
    // A writeback from d selects q_mem=0 even with rom_enable set.
    i_tag = 20'h000BB;
    d_tag = 20'h01234;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkGrant("pair_wb", 2'd2, 20'h01234, 1'b1, 1'b0, 1'b0);
    finishXfer("pair_wb", 3'b010);
    d_write = 1'b0;
    d_tag   = 20'h05678;
    toIdle("pair_wb");
    tick();
    checkGrant("pair_fill", 2'd2, 20'h05678, 1'b0, 1'b1, 1'b0);
    finishXfer("pair_fill", 3'b010);
    d_req = 1'b0;
    toIdle("pair_fill");
    tick();
    checkGrant("pair_i", 2'd1, 20'h000BB, 1'b0, 1'b1, 1'b1);
    finishXfer("pair_i", 3'b100);
    i_req = 1'b0;
    toIdle("pair_i");

    // Reset in the middle of a d transfer, then a re-grant.
    d_tag = 20'h000CC;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkGrant("rst_mid", 2'd2, 20'h000CC, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_mid.q_req",  32'(q_req),  32'd0);
    checkOutput("rst_mid.owner",  32'(owner),  32'd0);
    checkOutput("rst_mid.busy",   32'(busy),   32'd0);
    checkOutput("rst_mid.d_done", 32'(d_done), 32'd0);
    checkOutput("rst_mid.x_wait", 32'(dut.x_wait), 32'd0);
    tick();
    checkGrant("rst_regrant", 2'd2, 20'h000CC, 1'b0, 1'b1, 1'b0);
    finishXfer("rst_regrant", 3'b010);
    d_req = 1'b0;
    toIdle("rst_regrant");

    // Starvation: x loses four grants and then wins over a pending d.
    x_tag   = 20'h000DD;
    x_mem   = 1'b0;
    x_write = 1'b0;
    d_tag   = 20'h00D00;
    i_tag   = 20'h00100;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkGrant("starve1", 2'd2, 20'h00D00, 1'b1, 1'b0, 1'b0);
    checkOutput("starve1.x_wait", 32'(dut.x_wait), 32'd1);
    finishXfer("starve1", 3'b010);
    d_req = 1'b0;
    toIdle("starve1");
    tick();
    checkGrant("starve2", 2'd1, 20'h00100, 1'b0, 1'b1, 1'b1);
    checkOutput("starve2.x_wait", 32'(dut.x_wait), 32'd2);
    finishXfer("starve2", 3'b100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    toIdle("starve2");
    tick();
    checkGrant("starve3", 2'd2, 20'h00D00, 1'b1, 1'b0, 1'b0);
    checkOutput("starve3.x_wait", 32'(dut.x_wait), 32'd3);
    finishXfer("starve3", 3'b010);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    toIdle("starve3");
    tick();
    checkGrant("starve4", 2'd1, 20'h00100, 1'b0, 1'b1, 1'b1);
    checkOutput("starve4.x_wait", 32'(dut.x_wait), 32'd4);
    finishXfer("starve4", 3'b100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    toIdle("starve4");
    tick();
    checkGrant("starve5_x", 2'd3, 20'h000DD, 1'b0, 1'b0, 1'b0);
    checkOutput("starve5.x_wait", 32'(dut.x_wait), 32'd0);
    finishXfer("starve5_x", 3'b001);
    x_req = 1'b0;
    toIdle("starve5_x");
    tick();
    checkGrant("after_x_d", 2'd2, 20'h00D00, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Arbitrates the single QSPI line-transfer engine between three requesters: instruction-cache fill (i), data-cache writeback/fill (d) and an auxiliary line mover (x, e.g. SD/DMA).
- Latches the winner's tag and transfer type, then holds the engine until it reports line completion.
- Returns a one-cycle done pulse to the winner.
- Sits between icache/dcache and qspi at the core top level, replacing the inline request/mux logic there.

Parameters:
- PA, 22, physical address width
- LINE_LENGTH, 4, cache line length in bytes; tags are PA-1:$clog2(LINE_LENGTH)
- X_WAIT_MAX, 4, number of grants x may lose while requesting before it is forced to win

Ports:
- clk  in  1  clock
- reset  in  1  reset
- rom_enable  in  1  QSPI ROM mode enable from execute
- i_req  in  1  icache needs a line fill; level, held until i_done
- i_tag  in  PA-$clog2(LINE_LENGTH)  icache line tag
- i_done  out  1  one-cycle pulse: i transfer finished
- d_req  in  1  dcache needs a line transfer; level, held until d_done
- d_write  in  1  1 = writeback (push), 0 = fill (pull)
- d_tag  in  PA-$clog2(LINE_LENGTH)  dcache line tag
- d_done  out  1  one-cycle pulse: d transfer finished
- x_req  in  1  aux requester; level, held until x_done
- x_write  in  1  aux transfer direction
- x_mem  in  1  aux selects memory (1) or ROM-side device (0)
- x_tag  in  PA-$clog2(LINE_LENGTH)  aux line tag
- x_done  out  1  one-cycle pulse: x transfer finished
- q_req  out  1  request to qspi
- q_i_d  out  1  1 when the current owner is i
- q_write  out  1  qspi write direction
- q_mem  out  1  qspi mem select
- q_paddr  out  PA-$clog2(LINE_LENGTH)  qspi line tag
- q_done  in  1  qspi: last nibble of line transferred (one cycle)
- busy  out  1  arbiter not IDLE
- owner  out  2  0 none, 1 i, 2 d, 3 x

Behaviour:
- Reset is synchronous, active-high, and applies even mid-transfer.
  - Outputs after reset: state IDLE, q_req=0, q_i_d=0, q_write=0, q_mem=0, q_paddr=0, all *_done=0, busy=0, owner=0.
  - The x_wait counter and the pair flag are cleared.
- States: IDLE, XFER, TURN.
- IDLE: if any request is high, select a winner.
  - Register owner, tag, write and mem; go to XFER.
  - q_req=1 starting the next cycle, so latency from request to q_req is 1 clock.
  - No request: stay in IDLE.
- Winner priority, highest first:
  1. d continuation: the pair flag is set and d_req=1 with d_write=0.
  2. x, when x_wait==X_WAIT_MAX.
  3. d.
  4. i.
  5. x.
- Registered fields per owner:
  - q_mem: i gives rom_enable; d gives rom_enable&&!d_write; x gives x_mem.
  - q_write: i gives 0; d gives d_write; x gives x_write.
  - q_i_d=1 only when owner is i.
- XFER: q_req held at 1; q_paddr, q_write, q_mem and q_i_d are stable for the whole transfer.
  - On q_done=1: go to TURN; q_req=0 from the next cycle.
- TURN: the owner's *_done is 1 for exactly this one cycle; q_req=0, which gives qspi one idle cycle to release chip select.
  - Pair flag: set if the finished transfer was a d writeback, cleared otherwise.
  - Next state is always IDLE.
  - Done-to-next-q_req latency is 2 clocks minimum.
- Request dropped mid-XFER: ignored. The transfer runs to q_done and *_done is still pulsed. qspi cannot abort.
- q_done outside XFER: ignored.
- x_wait counter:
  - Increments, saturating at X_WAIT_MAX, at each IDLE grant to i or d while x_req=1.
  - Cleared on a grant to x.
  - Width $clog2(X_WAIT_MAX+1).
- Pair flag: cleared when any grant other than a d continuation is made.
- Requests arriving simultaneously with q_done are arbitrated in the IDLE following TURN.
- busy=1 in XFER and TURN.

Test Plan:
- Reset mid-XFER (owner d, q_req=1) -> next cycle: q_req=0, owner=0, busy=0, no d_done; d_req still high -> re-granted 1 cycle after reset drops.
- i_req, d_req(d_write=0) and x_req all rise in the same IDLE cycle -> owner=2, q_write=0, q_mem=rom_enable; after q_done, d_done pulses one cycle; next grant i, then x.
- Pair: d_write=1 with tag 0x1234, i_req also high; q_done, then d switches to d_write=0 with tag 0x5678 -> the next grant is d (fill, q_paddr=0x5678) ahead of i.
- Starvation, X_WAIT_MAX=4: x_req held while i and d alternately re-request -> x_wait counts 1..4; the 5th grant goes to x even with d_req=1; x_wait then reads 0.
- i_req dropped in cycle 2 of XFER -> q_req stays 1 until q_done; i_done pulses in TURN; IDLE follows, with no grant if no requests.
- rom_enable=1, d_write=1 -> q_mem=0; i owner -> q_mem=1 and q_i_d=1; x_mem=0 with x owner -> q_mem=0 regardless of rom_enable.
